// File: rtl/roc_pkg.sv
// roc_pkg: shared types and helpers for the RoC tick scheduler and command_controller
//   roc_state_e : scheduler FSM states
//   TPS_W       : width of the ticks-per-second word (o_roc_tps / i_tps)
//   roc_rate()  : clamps a requested rate to the clock frequency
package roc_pkg;

   localparam int TPS_W = 32;

   typedef enum logic [1:0] {
      s_IDLE   = 2'd0,
      s_TICK   = 2'd1,
      s_SETTLE = 2'd2
   } roc_state_e;

   // Effective rate: a request above the clock rate would need more than one credit per cycle.
   function automatic logic [TPS_W:0] roc_rate(input logic [TPS_W-1:0] tps, input logic [TPS_W:0] hz);
      return ({1'b0, tps} > hz) ? hz : {1'b0, tps};
   endfunction

endpackage

// File: rtl/roc_phase_acc.sv
// roc_phase_acc: fractional phase accumulator producing one credit pulse per rate period
//   i_clk, i_rst_n : clock, async active-low reset
//   i_en           : run enable; low holds the accumulator at 0
//   i_tps          : requested ticks per second (clamped to CLK_HZ)
//   o_credit       : combinational one-cycle pulse when the phase wraps this cycle
module roc_phase_acc
   import roc_pkg::*;
#(
   parameter int unsigned CLK_HZ = 50_000_000
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_en,
   input  logic [TPS_W-1:0] i_tps,
   output logic             o_credit
);

   localparam logic [TPS_W:0] HZ = (TPS_W+1)'(CLK_HZ);

   logic [TPS_W:0] acc_q, acc_d, rate, sum;
   logic           run;

   // acc < HZ and rate <= HZ, so the sum always fits in TPS_W+1 bits.
   always_comb begin
      rate     = roc_rate(i_tps, HZ);
      sum      = acc_q + rate;
      run      = i_en && (rate != '0);
      o_credit = run && (sum >= HZ);
      acc_d    = !run ? '0 : o_credit ? sum - HZ : sum;
   end

   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) acc_q <= '0;
      else          acc_q <= acc_d;

endmodule

// File: rtl/roc_tick_scheduler.sv
// roc_tick_scheduler: turns a ticks-per-second rate and enable into spaced single-cycle RoC ticks
//   i_clk, i_rst_n     : clock, async active-low reset
//   i_en, i_tps        : run enable and target rate (0 = no free-running ticks)
//   i_step, i_clear    : one-extra-tick request; clear of overrun and tick count
//   i_roc_outputs      : live RoC outputs, sampled at the end of settle
//   o_tick, o_busy     : tick strobe; high while a tick is in flight
//   o_tick_count       : ticks issued since reset/clear (wraps)
//   o_overrun          : sticky, a credit was dropped at MAX_PENDING
//   o_snapshot, o_snap_valid : captured RoC outputs and their update pulse
module roc_tick_scheduler
   import roc_pkg::*;
#(
   parameter int unsigned CLK_HZ        = 50_000_000,
   parameter int unsigned SETTLE_CYCLES = 4,
   parameter int unsigned MAX_PENDING   = 3,
   parameter int unsigned ROC_OUTPUTS   = 8
) (
   input  logic                   i_clk,
   input  logic                   i_rst_n,
   input  logic                   i_en,
   input  logic [TPS_W-1:0]       i_tps,
   input  logic                   i_step,
   input  logic                   i_clear,
   input  logic [ROC_OUTPUTS-1:0] i_roc_outputs,
   output logic                   o_tick,
   output logic                   o_busy,
   output logic [31:0]            o_tick_count,
   output logic                   o_overrun,
   output logic [ROC_OUTPUTS-1:0] o_snapshot,
   output logic                   o_snap_valid
);

   localparam int CW  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam int CRW = $clog2(MAX_PENDING + 3);

   roc_state_e             state_q;
   logic [CW-1:0]          cnt_q;
   logic [CRW-1:0]         cred_q, cred_d, avail, net;
   logic [31:0]            count_q, count_d;
   logic                   ovr_q, ovr_d, snapv_q, credit, issue, drop, legal;
   logic [ROC_OUTPUTS-1:0] snap_q;

   roc_phase_acc #(.CLK_HZ(CLK_HZ)) u_acc (
      .i_clk    (i_clk),
      .i_rst_n  (i_rst_n),
      .i_en     (i_en),
      .i_tps    (i_tps),
      .o_credit (credit)
   );

   // avail includes this cycle's incoming credit/step so an idle FSM can start the tick next cycle.
   always_comb begin
      legal   = (state_q == s_IDLE) || (state_q == s_TICK) || (state_q == s_SETTLE);
      issue   = (state_q == s_TICK);
      avail   = (i_en ? cred_q : '0) + CRW'(credit) + CRW'(i_step);
      net     = (avail > CRW'(issue)) ? avail - CRW'(issue) : '0;
      drop    = net > CRW'(MAX_PENDING);
      cred_d  = !legal ? '0 : drop ? CRW'(MAX_PENDING) : net;
      ovr_d   = (ovr_q & ~i_clear) | drop;
      count_d = (i_clear ? '0 : count_q) + 32'(issue);
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= s_IDLE;
         cnt_q   <= '0;
         cred_q  <= '0;
         count_q <= '0;
         ovr_q   <= 1'b0;
         snap_q  <= '0;
         snapv_q <= 1'b0;
      end else begin
         cred_q  <= cred_d;
         count_q <= count_d;
         ovr_q   <= ovr_d;
         snapv_q <= 1'b0;
         case (state_q)
            s_IDLE:
               if (avail != '0) state_q <= s_TICK;
            s_TICK: begin
               cnt_q   <= CW'(SETTLE_CYCLES - 1);
               state_q <= s_SETTLE;
            end
            s_SETTLE:
               if (cnt_q == '0) begin
                  snap_q  <= i_roc_outputs;
                  snapv_q <= 1'b1;
                  state_q <= s_IDLE;
               end else cnt_q <= cnt_q - 1'b1;
            default: state_q <= s_IDLE;
         endcase
      end
   end

   assign o_tick       = (state_q == s_TICK);
   assign o_busy       = (state_q == s_TICK) || (state_q == s_SETTLE);
   assign o_tick_count = count_q;
   assign o_overrun    = ovr_q;
   assign o_snapshot   = snap_q;
   assign o_snap_valid = snapv_q;

endmodule

// File: tb/tb_roc_tick_scheduler.sv
// tb_roc_tick_scheduler: randomized self-checking bench against a cycle-level behavioural model
module tb_roc_tick_scheduler;

   localparam int unsigned HZ   = 100;
   localparam int          S    = 4;
   localparam int          MAXP = 3;

   logic        clk = 1'b0, rst_n = 1'b0;
   logic        en = 1'b0, step = 1'b0, clear = 1'b0;
   logic [31:0] tps = '0;
   logic [7:0]  roc = '0;
   logic        tick, busy, ovr, snapv;
   logic [31:0] count;
   logic [7:0]  snap;

   int n_checks = 0, n_fail = 0;

   longint      m_acc = 0;
   int          m_cred = 0, m_since = -1;
   logic [31:0] m_count = '0;
   logic        m_ovr = 1'b0, m_snapv = 1'b0;
   logic [7:0]  m_snap = '0;

   roc_tick_scheduler #(.CLK_HZ(HZ), .SETTLE_CYCLES(S), .MAX_PENDING(MAXP), .ROC_OUTPUTS(8)) dut (
      .i_clk         (clk),
      .i_rst_n       (rst_n),
      .i_en          (en),
      .i_tps         (tps),
      .i_step        (step),
      .i_clear       (clear),
      .i_roc_outputs (roc),
      .o_tick        (tick),
      .o_busy        (busy),
      .o_tick_count  (count),
      .o_overrun     (ovr),
      .o_snapshot    (snap),
      .o_snap_valid  (snapv)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // m_since: -1 idle, 0 the tick cycle, 1..S settling; capture happens in the last settle cycle.
   task automatic model(input logic e, input logic [31:0] t, input logic s, input logic c, input logic [7:0] r);
      longint rate;
      int     avail, nc;
      logic   credit, issue, dropped;
      rate   = (longint'(t) > longint'(HZ)) ? longint'(HZ) : longint'(t);
      credit = 1'b0;
      if (!e || rate == 0) m_acc = 0;
      else begin
         m_acc += rate;
         if (m_acc >= HZ) begin
            m_acc -= HZ;
            credit = 1'b1;
         end
      end
      avail   = (e ? m_cred : 0) + int'(credit) + int'(s);
      issue   = (m_since == 0);
      nc      = avail - int'(issue);
      if (nc < 0) nc = 0;
      dropped = nc > MAXP;
      if (dropped) nc = MAXP;
      m_cred  = nc;
      m_ovr   = (m_ovr && !c) || dropped;
      m_count = (c ? 32'd0 : m_count) + 32'(issue);
      m_snapv = (m_since == S);
      if (m_snapv) m_snap = r;
      if (m_since < 0) m_since = (avail > 0) ? 0 : -1;
      else if (m_since < S) m_since++;
      else m_since = -1;
   endtask

   task automatic model_reset();
      m_acc = 0; m_cred = 0; m_since = -1; m_count = '0;
      m_ovr = 1'b0; m_snapv = 1'b0; m_snap = '0;
   endtask

   task automatic compare_all();
      chk("tick", 32'(tick), 32'(m_since == 0));
      chk("busy", 32'(busy), 32'(m_since >= 0));
      chk("count", count, m_count);
      chk("overrun", 32'(ovr), 32'(m_ovr));
      chk("snap_valid", 32'(snapv), 32'(m_snapv));
      chk("snapshot", 32'(snap), 32'(m_snap));
   endtask

   task automatic cyc(input logic e, input logic [31:0] t, input logic s, input logic c, input logic [7:0] r);
      en = e; tps = t; step = s; clear = c; roc = r;
      model(e, t, s, c, r);
      @(negedge clk);
      compare_all();
   endtask

   task automatic check_reset_zero(input string tag);
      chk({tag, "_tick"}, 32'(tick), 32'd0);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_count"}, count, 32'd0);
      chk({tag, "_overrun"}, 32'(ovr), 32'd0);
      chk({tag, "_snapshot"}, 32'(snap), 32'd0);
      chk({tag, "_snap_valid"}, 32'(snapv), 32'd0);
   endtask

   initial begin
      logic [31:0] rates [10] = '{0, 1, 7, 10, 33, 50, 99, 100, 101, 1000};
      logic [31:0] t;
      logic        e;
      int          ticks, last, gap_bad;
      #2 check_reset_zero("reset");
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      compare_all();
      // steady rate 10: ticks exactly 10 cycles apart
      ticks = 0; last = -1; gap_bad = 0;
      for (int i = 0; i < 201; i++) begin
         cyc(1'b1, 32'd10, 1'b0, 1'b0, 8'($urandom));
         if (tick) begin
            if (last >= 0 && i - last != 10) gap_bad++;
            last = i;
            ticks++;
         end
      end
      chk("rate10_gaps", 32'(gap_bad), 32'd0);
      chk("rate10_ticks", 32'(ticks), 32'd20);
      // full rate: saturate credits, overrun, then clear
      for (int i = 0; i < 40; i++) cyc(1'b1, 32'd100, 1'b0, 1'b0, 8'($urandom));
      chk("full_rate_overrun", 32'(ovr), 32'd1);
      cyc(1'b1, 32'd100, 1'b0, 1'b1, 8'($urandom));
      // step while disabled captures a known value
      for (int i = 0; i < 8; i++) cyc(1'b0, 32'd100, 1'b0, 1'b0, 8'hA5);
      cyc(1'b0, 32'd0, 1'b1, 1'b0, 8'hA5);
      for (int i = 0; i < 8; i++) cyc(1'b0, 32'd0, 1'b0, 1'b0, 8'hA5);
      chk("step_snapshot", 32'(snap), 32'hA5);
      // zero rate, then 50
      for (int i = 0; i < 500; i++) cyc(1'b1, 32'd0, 1'b0, 1'b0, 8'($urandom));
      for (int i = 0; i < 40; i++) cyc(1'b1, 32'd50, 1'b0, 1'b0, 8'($urandom));
      // enable drop while a tick is settling
      for (int i = 0; i < 3; i++) cyc(1'b1, 32'd100, 1'b0, 1'b0, 8'($urandom));
      for (int i = 0; i < 20; i++) cyc(1'b0, 32'd100, 1'b0, 1'b0, 8'($urandom));
      // random mix including steps, clears and over-range rates
      for (int i = 0; i < 3000; i++) begin
         t = ($urandom_range(0, 15) == 0) ? $urandom : rates[$urandom_range(0, 9)];
         e = ($urandom_range(0, 7) != 0);
         cyc(e, t, $urandom_range(0, 9) == 0, $urandom_range(0, 19) == 0, 8'($urandom));
      end
      // reset while settling
      for (int i = 0; i < 20 && !(m_since >= 1 && m_since <= S - 1); i++)
         cyc(1'b1, 32'd100, 1'b0, 1'b0, 8'($urandom));
      chk("pre_reset_busy", 32'(busy), 32'd1);
      en = 1'b0; step = 1'b0; clear = 1'b0;
      #2 rst_n = 1'b0;
      #1 check_reset_zero("async_reset");
      model_reset();
      @(negedge clk);
      compare_all();
      rst_n = 1'b1;
      for (int i = 0; i < 10; i++) cyc(1'b0, 32'd0, 1'b0, 1'b0, 8'($urandom));
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
